encoder: RTL



---
 rtl/enc8b10b_pkg.sv | 55 +++++
 rtl/enc_5b6b.sv | 26 ++
 rtl/encoder.sv | 86 ++++++++
 3 files changed

// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b code constants and helpers for the TX encoder.
// Code tables hold the RD- form; the RD+ form is derived by complement where the code is unbalanced.
package enc8b10b_pkg;

   localparam logic [9:0] K28_5_RDN = 10'h0FA;
   localparam logic [9:0] K28_5_RDP = 10'h305;

   localparam logic [4:0] K_X_28 = 5'd28;
   localparam logic [4:0] K_X_23 = 5'd23;
   localparam logic [4:0] K_X_27 = 5'd27;
   localparam logic [4:0] K_X_29 = 5'd29;
   localparam logic [4:0] K_X_30 = 5'd30;

   // abcdei, index = EDCBA, RD- column
   localparam logic [5:0] CODE6_RDN [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001,
      6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110,
      6'b001110, 6'b101110, 6'b011110, 6'b101011
   };
   localparam logic [5:0] K28_6B_RDN = 6'b001111;

   // fghj, index = HGF, RD- column (entry 7 is the primary P7 form)
   localparam logic [3:0] CODE4_RDN [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100,
      4'b1101, 4'b1010, 4'b0110, 4'b1110
   };
   localparam logic [3:0] A7_RDN = 4'b0111;

   function automatic logic [2:0] ones6(input logic [5:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
      return n;
   endfunction

   function automatic logic [2:0] ones4(input logic [3:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
      return n;
   endfunction

   function automatic logic is_legal_k(input logic [7:0] b);
      logic [4:0] x;
      x = b[4:0];
      return (x == K_X_28) ||
             ((b[7:5] == 3'd7) && (x == K_X_23 || x == K_X_27 || x == K_X_29 || x == K_X_30));
   endfunction

endpackage

// File: rtl/enc_5b6b.sv
// Combinational 5b/6b stage: picks the 6b sub-block for the current RD and
// reports the mid-symbol running disparity.
module enc_5b6b
   import enc8b10b_pkg::*;
(
   input  logic [4:0] x_i,
   input  logic       k_i,
   input  logic       rd_i,
   output logic [5:0] code_o,
   output logic       rd_mid_o
);

   logic [5:0] base6;
   logic       unbal6;
   logic       is_d7;

   always_comb begin
      base6    = (k_i && (x_i == K_X_28)) ? K28_6B_RDN : CODE6_RDN[x_i];
      unbal6   = (ones6(base6) != 3'd3);
      // D.7 is balanced but still has distinct RD-/RD+ forms
      is_d7    = !k_i && (x_i == 5'd7);
      code_o   = (rd_i && (unbal6 || is_d7)) ? ~base6 : base6;
      rd_mid_o = rd_i ^ unbal6;
   end

endmodule

// File: rtl/encoder.sv
// TX 8b/10b encoder: byte/K select with idle-comma insertion, 3b/4b stage,
// running disparity tracking and registered 10-bit symbol output.
module encoder
   import enc8b10b_pkg::*;
#(
   parameter logic [7:0] IDLE_K  = 8'hBC,
   parameter logic       RD_INIT = 1'b0
)(
   input  logic       BitCLK_10,
   input  logic       Reset,
   input  logic       TxValid,
   input  logic [7:0] TxParallel_8,
   input  logic       TxDataK,
   output logic [9:0] TxParallel_10,
   output logic       TxDisparity,
   output logic       TxCodeErr
);

   logic [9:0] sym_q, sym_d;
   logic       rd_q, rd_d;
   logic       err_q, err_d;

   logic       use_idle;
   logic [7:0] byte_sel;
   logic       k_sel;
   logic [5:0] code6;
   logic       rd_mid;
   logic [2:0] y;
   logic [4:0] x;
   logic       use_a7;
   logic [3:0] base4;
   logic       unbal4;
   logic [3:0] code4;

   always_comb begin
      err_d    = TxValid && TxDataK && !is_legal_k(TxParallel_8);
      use_idle = !TxValid || err_d;
      byte_sel = use_idle ? IDLE_K : TxParallel_8;
      k_sel    = use_idle || TxDataK;
   end

   enc_5b6b u_5b6b (
      .x_i      (byte_sel[4:0]),
      .k_i      (k_sel),
      .rd_i     (rd_q),
      .code_o   (code6),
      .rd_mid_o (rd_mid)
   );

   always_comb begin
      y      = byte_sel[7:5];
      x      = byte_sel[4:0];
      // A7 avoids a run of five equal bits across the 6b/4b boundary
      use_a7 = (y == 3'd7) &&
               (k_sel ||
                (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
      base4  = use_a7 ? A7_RDN : CODE4_RDN[y];
      unbal4 = (ones4(base4) != 3'd2);
      if (k_sel && !unbal4 && (y != 3'd3))
         code4 = rd_mid ? base4 : ~base4;
      else if (rd_mid && (unbal4 || (y == 3'd3)))
         code4 = ~base4;
      else
         code4 = base4;
      rd_d   = rd_mid ^ unbal4;
      sym_d  = {code6, code4};
   end

   always_ff @(posedge BitCLK_10 or negedge Reset) begin
      if (!Reset) begin
         sym_q <= K28_5_RDN;
         rd_q  <= RD_INIT;
         err_q <= 1'b0;
      end else begin
         sym_q <= sym_d;
         rd_q  <= rd_d;
         err_q <= err_d;
      end
   end

   assign TxParallel_10 = sym_q;
   assign TxDisparity   = rd_q;
   assign TxCodeErr     = err_q;

endmodule
